// File: rtl/l2_arb_pkg.sv
// Shared types and defaults for the dual-L1 to shared-L2 arbiter.
package l2_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                  wr;
        logic                  lock;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } l2_req_t;

endpackage

// File: rtl/rr_picker2.sv
// Two-way round-robin picker; mask restricts eligibility (used for lock hold).
module rr_picker2
    import l2_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last,
    input  logic [1:0] mask,
    output logic [1:0] grant,
    output logic       grant_id
);

    logic [1:0] elig;
    assign elig = valid & mask;

    always_comb begin
        grant    = 2'b00;
        grant_id = 1'b0;
        if (elig == 2'b11) begin
            // Contention: favour whoever did not complete last.
            grant_id = ~last;
            grant    = last ? 2'b01 : 2'b10;
        end else if (elig[1]) begin
            grant_id = 1'b1;
            grant    = 2'b10;
        end else if (elig[0]) begin
            grant    = 2'b01;
        end
    end

endmodule

// File: rtl/l2_arbiter.sv
// Arbitrates two L1 caches onto one L2 port, one transaction outstanding at a time.
// Optional atomic hold (LL/SC) enabled by defining L2_ARB_LOCK_EN.
module l2_arbiter
    import l2_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_wr,
    input  logic [1:0]        req_lock,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        req_ready,
    output logic [1:0]        resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              l2_req_valid,
    output logic              l2_req_wr,
    output logic [ADDR_W-1:0] l2_req_addr,
    output logic [DATA_W-1:0] l2_req_wdata,
    input  logic              l2_req_ready,
    input  logic              l2_resp_valid,
    input  logic [DATA_W-1:0] l2_resp_rdata,
    output logic              err_spurious
);

    arb_state_t        state_reg;
    logic              last_reg;
    logic              gnt_id_reg;
    logic              wr_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              err_reg;

    logic [1:0]        grant;
    logic              grant_id;
    logic [1:0]        mask;
    logic              resp_hit;

`ifdef L2_ARB_LOCK_EN
    logic              lock_reg;
    logic              hold_reg;
    logic              hold_id_reg;
    assign mask = hold_reg ? (hold_id_reg ? 2'b10 : 2'b01) : 2'b11;
`else
    logic              unused_lock;
    assign unused_lock = ^req_lock;
    assign mask        = 2'b11;
`endif

    rr_picker2 u_picker (
        .valid    (req_valid),
        .last     (last_reg),
        .mask     (mask),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // req_ready is combinational, so it must be gated while reset is held.
    assign req_ready    = (rst_n && state_reg == IDLE) ? grant : 2'b00;
    assign resp_hit     = (state_reg == WAIT) && l2_resp_valid;
    assign resp_valid   = resp_hit ? (gnt_id_reg ? 2'b10 : 2'b01) : 2'b00;
    assign resp_rdata   = resp_hit ? l2_resp_rdata : '0;
    assign l2_req_valid = (state_reg == ISSUE);
    assign l2_req_wr    = wr_reg;
    assign l2_req_addr  = addr_reg;
    assign l2_req_wdata = wdata_reg;
    assign err_spurious = err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            last_reg    <= 1'b1;
            gnt_id_reg  <= 1'b0;
            wr_reg      <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            err_reg     <= 1'b0;
`ifdef L2_ARB_LOCK_EN
            lock_reg    <= 1'b0;
            hold_reg    <= 1'b0;
            hold_id_reg <= 1'b0;
`endif
        end else begin
            if (l2_resp_valid && state_reg != WAIT) begin
                err_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (|grant) begin
                        gnt_id_reg <= grant_id;
                        wr_reg     <= grant_id ? req_wr[1] : req_wr[0];
                        addr_reg   <= grant_id ? req_addr1 : req_addr0;
                        wdata_reg  <= grant_id ? req_wdata1 : req_wdata0;
`ifdef L2_ARB_LOCK_EN
                        lock_reg   <= grant_id ? req_lock[1] : req_lock[0];
`endif
                        state_reg  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (l2_req_ready) begin
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (l2_resp_valid) begin
                        last_reg    <= gnt_id_reg;
`ifdef L2_ARB_LOCK_EN
                        // A locked completion pins the next grant to the same requester.
                        hold_reg    <= lock_reg;
                        hold_id_reg <= gnt_id_reg;
`endif
                        state_reg   <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
